// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: ALU op encodings, FSM states
// and op-class helpers.
package mem_access_pkg;

  localparam logic [7:0] ALU_OP_ADD = 8'h00;
  localparam logic [7:0] ALU_OP_LB  = 8'h10;
  localparam logic [7:0] ALU_OP_LH  = 8'h11;
  localparam logic [7:0] ALU_OP_LW  = 8'h12;
  localparam logic [7:0] ALU_OP_LBU = 8'h14;
  localparam logic [7:0] ALU_OP_LHU = 8'h15;
  localparam logic [7:0] ALU_OP_SB  = 8'h18;
  localparam logic [7:0] ALU_OP_SH  = 8'h19;
  localparam logic [7:0] ALU_OP_SW  = 8'h1A;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_load(input logic [7:0] op);
    return (op == ALU_OP_LB) || (op == ALU_OP_LH) || (op == ALU_OP_LW) ||
           (op == ALU_OP_LBU) || (op == ALU_OP_LHU);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == ALU_OP_SB) || (op == ALU_OP_SH) || (op == ALU_OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load-data expansion: selects the byte/half at the given offset of an aligned
// word and sign- or zero-extends it according to the load op.
module mem_access_load_extend
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [7:0]      op,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection followed by extension
  always_comb begin
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    data     = rdata;
    case (off)
      2'd0: begin sel_byte = rdata[7:0];   sel_half = rdata[15:0];  end
      2'd1: begin sel_byte = rdata[15:8];  sel_half = rdata[23:8];  end
      2'd2: begin sel_byte = rdata[23:16]; sel_half = rdata[31:16]; end
      // a half at offset 3 is rejected as misaligned before reaching memory
      default: begin sel_byte = rdata[31:24]; sel_half = {8'h00, rdata[31:24]}; end
    endcase
    case (op)
      ALU_OP_LB:  data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      ALU_OP_LBU: data = {{(XLEN-8){1'b0}}, sel_byte};
      ALU_OP_LH:  data = {{(XLEN-16){sel_half[15]}}, sel_half};
      ALU_OP_LHU: data = {{(XLEN-16){1'b0}}, sel_half};
      ALU_OP_LW:  data = rdata;
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: request/grant/response handshake with data memory,
// load expansion, and a valid/ready hand-off of one result to write-back.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ALU_OP_W = 8,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [XLEN-1:0]     alu_result_i,
  input  logic [XLEN-1:0]     rmem_addr_i,
  input  logic [XLEN-1:0]     wmem_addr_i,
  input  logic [7:0]          wmem_mask_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [4:0]          rd_i,
  input  logic                rd_we_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [3:0]          mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [XLEN-1:0]     wb_data_o,
  output logic [4:0]          wb_rd_o,
  output logic                wb_we_o,
  output logic                misalign_o
);

  state_t          state, state_nxt;
  logic [7:0]      op_in, op;
  logic [1:0]      off_in, off;
  logic            ld_in, st_in, mis_in, accept, ld;
  logic [XLEN-1:0] ext_data;
  logic            unused_mask_hi;

  assign op_in          = 8'(alu_op_i);
  assign unused_mask_hi = ^wmem_mask_i[7:4];

  assign ex_ready_o = (state == ST_IDLE);
  assign mem_req_o  = (state == ST_REQ);
  assign wb_valid_o = (state == ST_WB);

  // Classify the incoming op and detect accesses that must be dropped
  always_comb begin
    ld_in  = is_load(op_in);
    st_in  = is_store(op_in);
    off_in = 2'b00;
    mis_in = 1'b0;
    if (ld_in) begin
      off_in = rmem_addr_i[1:0];
    end else if (st_in) begin
      off_in = wmem_addr_i[1:0];
    end else begin
      off_in = 2'b00;
    end
    if (st_in) begin
      mis_in = (wmem_mask_i[3:0] == 4'h0);
    end else if (op_in == ALU_OP_LW) begin
      mis_in = (off_in != 2'b00);
    end else if ((op_in == ALU_OP_LH) || (op_in == ALU_OP_LHU)) begin
      mis_in = (off_in == 2'b11);
    end else begin
      mis_in = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_valid_i) begin
          accept = 1'b1;
          if ((ld_in || st_in) && !mis_in) state_nxt = ST_REQ;
          else                             state_nxt = ST_WB;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) state_nxt = ld ? ST_WAIT : ST_WB;
        else           state_nxt = ST_REQ;
      end
      ST_WAIT: begin
        if (mem_rvalid_i) state_nxt = ST_WB;
        else              state_nxt = ST_WAIT;
      end
      ST_WB: begin
        if (wb_ready_i) state_nxt = ST_IDLE;
        else            state_nxt = ST_WB;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Latched payload and write-back result
  always_ff @(posedge clk) begin
    if (rst) begin
      op          <= 8'h00;
      off         <= 2'b00;
      ld          <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= {XLEN{1'b0}};
      mem_wdata_o <= {XLEN{1'b0}};
      mem_wmask_o <= 4'h0;
      wb_data_o   <= {XLEN{1'b0}};
      wb_rd_o     <= 5'd0;
      wb_we_o     <= 1'b0;
      misalign_o  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      if (accept) begin
        op         <= op_in;
        off        <= off_in;
        ld         <= ld_in && !mis_in;
        wb_rd_o    <= rd_i;
        misalign_o <= mis_in;
        if (mis_in) begin
          wb_data_o <= {XLEN{1'b0}};
          wb_we_o   <= 1'b0;
        end else if (ld_in) begin
          mem_we_o    <= 1'b0;
          mem_addr_o  <= {rmem_addr_i[XLEN-1:2], 2'b00};
          mem_wdata_o <= {XLEN{1'b0}};
          mem_wmask_o <= 4'h0;
          wb_data_o   <= {XLEN{1'b0}};
          wb_we_o     <= rd_we_i && (rd_i != 5'd0);
        end else if (st_in) begin
          mem_we_o    <= 1'b1;
          mem_addr_o  <= {wmem_addr_i[XLEN-1:2], 2'b00};
          mem_wdata_o <= wdata_i << {off_in, 3'b000};
          mem_wmask_o <= wmem_mask_i[3:0];
          wb_data_o   <= {XLEN{1'b0}};
          wb_we_o     <= 1'b0;
        end else begin
          wb_data_o <= alu_result_i;
          wb_we_o   <= rd_we_i && (rd_i != 5'd0);
        end
      end else if ((state == ST_WAIT) && mem_rvalid_i) begin
        wb_data_o <= ext_data;
      end
    end
  end

  mem_access_load_extend #(.XLEN(XLEN)) u_load_extend (
    .op    (op),
    .off   (off),
    .rdata (mem_rdata_i),
    .data  (ext_data)
  );

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: passthrough, loads, stores,
// grant/rvalid stalls, misaligned drops and reset during an outstanding load.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_ready_o;
  logic [7:0]  alu_op_i;
  logic [31:0] alu_result_i, rmem_addr_i, wmem_addr_i, wdata_i;
  logic [7:0]  wmem_mask_i;
  logic [4:0]  rd_i, wb_rd_o;
  logic        rd_we_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, wb_data_o;
  logic [3:0]  mem_wmask_o;
  logic        wb_valid_o, wb_ready_i, wb_we_o, misalign_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access #(.ALU_OP_W(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .alu_op_i(alu_op_i), .alu_result_i(alu_result_i),
    .rmem_addr_i(rmem_addr_i), .wmem_addr_i(wmem_addr_i),
    .wmem_mask_i(wmem_mask_i), .wdata_i(wdata_i),
    .rd_i(rd_i), .rd_we_i(rd_we_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .misalign_o(misalign_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] raddr,
                       input logic [31:0] waddr, input logic [7:0] mask,
                       input logic [31:0] wd, input logic [4:0] rd);
    ex_valid_i  = 1'b1;
    alu_op_i    = op;
    rmem_addr_i = raddr;
    wmem_addr_i = waddr;
    wmem_mask_i = mask;
    wdata_i     = wd;
    rd_i        = rd;
    rd_we_i     = 1'b1;
    step();
    ex_valid_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; alu_op_i = ALU_OP_ADD; alu_result_i = 32'h0;
    rmem_addr_i = 32'h0; wmem_addr_i = 32'h0; wmem_mask_i = 8'h00; wdata_i = 32'h0;
    rd_i = 5'd0; rd_we_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0; wb_ready_i = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_ex_ready", {31'd0, ex_ready_o}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_mem_req",  {31'd0, mem_req_o}, 32'd0);
    check("rst_wb_data",  wb_data_o, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);

    // ADD passthrough
    alu_result_i = 32'h0000_1234;
    issue(ALU_OP_ADD, 32'h0, 32'h0, 8'h00, 32'h0, 5'd5);
    check("add_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("add_wb_data",  wb_data_o, 32'h0000_1234);
    check("add_wb_we",    {31'd0, wb_we_o}, 32'd1);
    check("add_wb_rd",    {27'd0, wb_rd_o}, 32'd5);
    check("add_ex_ready", {31'd0, ex_ready_o}, 32'd0);
    step();
    check("add_back_idle", {31'd0, ex_ready_o}, 32'd1);

    // LB then LBU at byte offset 3
    for (int k = 0; k < 2; k++) begin
      issue((k == 0) ? ALU_OP_LB : ALU_OP_LBU, 32'h8000_0003, 32'h0, 8'h00, 32'h0, 5'd3);
      check("lb_req",  {31'd0, mem_req_o}, 32'd1);
      check("lb_addr", mem_addr_o, 32'h8000_0000);
      check("lb_we",   {31'd0, mem_we_o}, 32'd0);
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_0000;
      check("lb_req_drop", {31'd0, mem_req_o}, 32'd0);
      step();
      mem_rvalid_i = 1'b0;
      check("lb_wb_valid", {31'd0, wb_valid_o}, 32'd1);
      check("lb_wb_data", wb_data_o, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
      check("lb_wb_we", {31'd0, wb_we_o}, 32'd1);
      step();
    end

    // SH at 0x1002, then hold the result with wb_ready low for a cycle
    issue(ALU_OP_SH, 32'h0, 32'h0000_1002, 8'h0C, 32'h0000_ABCD, 5'd7);
    check("sh_req",   {31'd0, mem_req_o}, 32'd1);
    check("sh_we",    {31'd0, mem_we_o}, 32'd1);
    check("sh_addr",  mem_addr_o, 32'h0000_1000);
    check("sh_wdata", mem_wdata_o, 32'hABCD_0000);
    check("sh_wmask", {28'd0, mem_wmask_o}, 32'hC);
    mem_gnt_i = 1'b1; wb_ready_i = 1'b0;
    step();
    mem_gnt_i = 1'b0;
    check("sh_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("sh_wb_we",    {31'd0, wb_we_o}, 32'd0);
    step();
    check("sh_hold_valid", {31'd0, wb_valid_o}, 32'd1);
    check("sh_hold_ready", {31'd0, ex_ready_o}, 32'd0);
    wb_ready_i = 1'b1;
    step();
    check("sh_idle", {31'd0, ex_ready_o}, 32'd1);

    // LW with 3-cycle grant stall and rvalid 2 cycles late: result in t+8
    issue(ALU_OP_LW, 32'h0000_2000, 32'h0, 8'h00, 32'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      check("lw_stall_req",  {31'd0, mem_req_o}, 32'd1);
      check("lw_stall_addr", mem_addr_o, 32'h0000_2000);
      step();
    end
    mem_gnt_i = 1'b1;
    check("lw_gnt_req", {31'd0, mem_req_o}, 32'd1);
    step();
    mem_gnt_i = 1'b0;
    check("lw_wait_req", {31'd0, mem_req_o}, 32'd0);
    step(); step();
    check("lw_t7_valid", {31'd0, wb_valid_o}, 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    step();
    mem_rvalid_i = 1'b0;
    check("lw_t8_valid", {31'd0, wb_valid_o}, 32'd1);
    check("lw_t8_data",  wb_data_o, 32'hDEAD_BEEF);
    step();

    // misaligned LW: dropped, single misalign pulse
    wb_ready_i = 1'b0;
    issue(ALU_OP_LW, 32'h0000_1001, 32'h0, 8'h00, 32'h0, 5'd4);
    check("mis_pulse",    {31'd0, misalign_o}, 32'd1);
    check("mis_req",      {31'd0, mem_req_o}, 32'd0);
    check("mis_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    check("mis_wb_data",  wb_data_o, 32'h0);
    check("mis_wb_we",    {31'd0, wb_we_o}, 32'd0);
    step();
    check("mis_pulse_end", {31'd0, misalign_o}, 32'd0);
    check("mis_req_still", {31'd0, mem_req_o}, 32'd0);
    wb_ready_i = 1'b1;
    step();

    // store with zero mask is misaligned as well
    issue(ALU_OP_SB, 32'h0, 32'h0000_0040, 8'h00, 32'h0000_0011, 5'd1);
    check("sb0_pulse", {31'd0, misalign_o}, 32'd1);
    check("sb0_req",   {31'd0, mem_req_o}, 32'd0);
    step();

    // LH at offset 2 sign-extends; rd = 0 suppresses the write
    issue(ALU_OP_LH, 32'h0000_3002, 32'h0, 8'h00, 32'h0, 5'd0);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8001_7777;
    step();
    mem_rvalid_i = 1'b0;
    check("lh_wb_data", wb_data_o, 32'hFFFF_8001);
    check("lh_rd0_we",  {31'd0, wb_we_o}, 32'd0);
    step();

    // reset while waiting for load data; the late rvalid is ignored
    issue(ALU_OP_LW, 32'h0000_4000, 32'h0, 8'h00, 32'h0, 5'd2);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_req", {31'd0, mem_req_o}, 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    step();
    mem_rvalid_i = 1'b0;
    check("rstw_ex_ready", {31'd0, ex_ready_o}, 32'd1);
    check("rstw_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    step();
    check("rstw_wb_valid2", {31'd0, wb_valid_o}, 32'd0);
    check("rstw_wb_data",   wb_data_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute stage. It takes the latched execute outputs (ALU op, read/write address, byte mask, store data, ALU result), runs a request/grant/response handshake with the data memory, and expands load data by byte offset with sign or zero extension. It hands one result per instruction to write-back through a valid/ready handshake. Non-memory ops pass through with one cycle of latency.

## Interface
Parameters:
- ALU_OP_W, 8, width of the ALU op code; encodings come from the shared defines.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  execute presents an instruction
- ex_ready_o  out  1  stage can accept; high only in IDLE
- alu_op_i  in  ALU_OP_W  operation (LB/LH/LW/LBU/LHU/SB/SH/SW/other)
- alu_result_i  in  XLEN  result for non-memory ops
- rmem_addr_i  in  XLEN  load byte address
- wmem_addr_i  in  XLEN  store byte address
- wmem_mask_i  in  8  store byte mask; bits [3:0] are used, and all-zero means misaligned
- wdata_i  in  XLEN  store data, unshifted (rs2)
- rd_i  in  5  destination register; rd_we_i  in  1  register write enable
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  XLEN  word-aligned address (addr & ~3)
- mem_wdata_o  out  XLEN  store data shifted by 8*offset
- mem_wmask_o  out  4  byte strobes
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  XLEN  aligned load word
- wb_valid_o  out  1  result available
- wb_ready_i  in  1  write-back accepts
- wb_data_o  out  XLEN  result; wb_rd_o  out  5; wb_we_o  out  1
- misalign_o  out  1  one-cycle pulse when a misaligned access is dropped

## Operation
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE, on ex_valid_i: latch all inputs and compute offset = addr[1:0].
  - Load: go to REQ.
  - Store with nonzero mask: go to REQ.
  - Non-memory op: wb_data = alu_result_i; go to WB.
  - Misaligned access (store mask = 0, LW with offset ≠ 0, LH/LHU with offset = 3): no memory request; wb_data = 0 and wb_we = 0; pulse misalign_o; go to WB.
- REQ: hold mem_req_o and all payload stable until mem_gnt_i.
  - Load granted: go to WAIT.
  - Store granted: go to WB with wb_we = 0.
- WAIT: on mem_rvalid_i, capture the expanded data and go to WB. mem_rvalid_i is ignored in every other state.
- Load expansion: byte = rdata[8*off +: 8], half = rdata[8*off +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- WB: hold wb_* stable while wb_valid_o = 1 and wb_ready_i = 0. Go to IDLE on wb_ready_i.
- Stores and misaligned ops always drive wb_we_o = 0. Otherwise wb_we_o = latched rd_we. rd = 0 forces wb_we_o = 0.

## Timing
- Reset values: state IDLE; ex_ready_o = 1 (IDLE); every other output 0.
- All outputs are registered or decoded from state; there is no combinational path from mem_* or wb_ready_i to any output.
- Accept at edge t. A non-memory op has wb_valid_o = 1 in cycle t+1.
- Load with grant in the first REQ cycle (t+1) and rvalid in t+2: wb_valid_o = 1 in t+3.
- Store with immediate grant: mem_req_o in t+1, wb_valid_o in t+2.
- A grant stall of N cycles adds N cycles. An rvalid delay of M cycles adds M cycles.
- The memory never asserts rvalid in the same cycle as gnt.
- Back-to-back: a new instruction can be accepted in the cycle after the WB handshake. Peak throughput is 1 per 2 cycles.
- rst asserted mid-operation: the stage is in IDLE on the next edge and mem_req_o drops. A late mem_rvalid_i arriving after reset is ignored.

## Structure
- The shared defines file holds the ALU_OP_* encodings, the state encodings and ZERO_WORD.
- One sub-module, load_extend: a combinational block taking op, offset and rdata and producing the extended word. It is reused by the data-path checker.
- The store shifter and misalign decode stay inline.

## Test plan
- ADD passthrough: alu_result = 0x1234, wb_ready_i = 1 -> wb_valid_o one cycle after accept, wb_data_o = 0x1234, wb_we_o = 1.
- LB at addr 0x80000003, rdata = 0x80FF_0000 -> mem_addr_o = 0x80000000, wb_data_o = 0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH at addr 0x1002, wdata = 0xABCD, mask = 0b1100 -> mem_wdata_o = 0xABCD0000, mem_wmask_o = 0xC, mem_we_o = 1, wb_we_o = 0.
- LW with gnt held low for 3 cycles, then rvalid 2 cycles later -> mem_addr_o and mem_req_o stable throughout; wb_valid_o in t+8.
- LW at addr 0x1001 -> no mem_req_o, misalign_o pulses once, wb_data_o = 0, wb_we_o = 0.
- rst during WAIT, then rvalid the next cycle -> state IDLE, wb_valid_o stays 0, ex_ready_o = 1.
